// File: rtl/adder_tree_result_collector.sv
// Result collector behind the 128-input adder tree: edge-detected capture into a FIFO,
// valid/ready drain, per-pass row counting. Optional row tags with `define ATC_ROW_TAG_EN.
module adder_tree_result_collector #(
    parameter int DW       = 32,
    parameter int DEPTH    = 8,
    parameter int NUM_ROWS = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ExE_finish,
    input  logic [DW-1:0]            summation,
    input  logic                     pass_start,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DW-1:0]            res_data,
`ifdef ATC_ROW_TAG_EN
    output logic [$clog2(NUM_ROWS)-1:0] res_row,
`endif
    output logic                     pass_done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_ROWS) + 1;
    localparam int RW = $clog2(NUM_ROWS);
`ifdef ATC_ROW_TAG_EN
    localparam int EW = DW + RW;
`else
    localparam int EW = DW;
`endif
    localparam logic [CW-1:0] ROWS_MAX = CW'(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d, count_base;
    logic          finish_q;
    logic          overflow_q;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [EW-1:0] entry;
    logic          capture, pop, accept, full, empty, counting;

    assign capture  = ExE_finish & ~finish_q;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop      = res_valid & res_ready;
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    assign accept   = capture & (~full | pop);
    assign counting = (state_q == RUN) || pass_start;
    assign count_base = pass_start ? '0 : count_q;

`ifdef ATC_ROW_TAG_EN
    logic [RW-1:0] row_tag;
    assign row_tag = counting ? count_base[RW-1:0] : '0;
    assign entry   = {row_tag, summation};
`else
    assign entry   = summation;
`endif

    always_comb begin
        count_d = count_base;
        state_d = state_q;
        if (pass_start)
            state_d = RUN;
        if (counting && capture)
            count_d = count_base + 1'b1;
        if (state_d == RUN && count_d == ROWS_MAX)
            state_d = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            finish_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            finish_q <= ExE_finish;
            if (capture && full && !pop)
                overflow_q <= 1'b1;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr[AW-1:0]] <= entry;
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign res_valid = ~empty;
    assign res_data  = res_valid ? head[DW-1:0] : '0;
`ifdef ATC_ROW_TAG_EN
    assign res_row   = res_valid ? head[EW-1:DW] : '0;
`endif
    assign pass_done = (state_q == DONE);
    assign overflow  = overflow_q;
    assign level     = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_adder_tree_result_collector.sv
// Scoreboard bench for adder_tree_result_collector (DEPTH=8, NUM_ROWS=4).
module tb_adder_tree_result_collector;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int NUM_ROWS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ExE_finish = 1'b0;
    logic [DW-1:0] summation = '0;
    logic          pass_start = 1'b0;
    logic          res_ready = 1'b0;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          pass_done;
    logic          overflow;
    logic [3:0]    level;
`ifdef ATC_ROW_TAG_EN
    logic [1:0]    res_row;
`endif

    logic [DW-1:0] exp_data[$];
    logic [1:0]    exp_row[$];
    int n_checks = 0;
    int n_pass = 0;

    adder_tree_result_collector #(.DW(DW), .DEPTH(DEPTH), .NUM_ROWS(NUM_ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .ExE_finish(ExE_finish), .summation(summation),
        .pass_start(pass_start), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data),
`ifdef ATC_ROW_TAG_EN
        .res_row(res_row),
`endif
        .pass_done(pass_done), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; ExE_finish = 1'b0; pass_start = 1'b0; res_ready = 1'b0;
        exp_data.delete(); exp_row.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse(input logic [DW-1:0] w, input logic [1:0] row);
        exp_data.push_back(w); exp_row.push_back(row);
        ExE_finish = 1'b1; summation = w;
        @(posedge clk); #1;
        ExE_finish = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_pass_start();
        pass_start = 1'b1;
        @(posedge clk); #1;
        pass_start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        res_ready = 1'b1;
        while (exp_data.size() > 0 && n < 4 * DEPTH) begin
            if (res_valid) begin
                n_checks++;
                if (res_data !== exp_data[0])
                    $display("FAIL %s_data: got %h, required %h", name, res_data, exp_data[0]);
                else n_pass++;
`ifdef ATC_ROW_TAG_EN
                n_checks++;
                if (res_row !== exp_row[0])
                    $display("FAIL %s_row: got %0d, required %0d", name, res_row, exp_row[0]);
                else n_pass++;
`endif
                void'(exp_data.pop_front());
                void'(exp_row.pop_front());
            end
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (exp_data.size() != 0)
            $display("FAIL %s_timeout: got %0d words left, required 0", name, exp_data.size());
        else n_pass++;
        res_ready = 1'b0;
        n_checks++;
        if (level !== 4'd0) $display("FAIL %s_level_empty: got %0d, required 0", name, level);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({res_valid, res_data, pass_done, overflow, level} !== '0)
            $display("FAIL reset_outputs: got v=%b d=%h pd=%b ov=%b lvl=%0d, required all 0",
                     res_valid, res_data, pass_done, overflow, level);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_in_order();
        logic [DW-1:0] words [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        do_reset();
        res_ready = 1'b1;
        do_pass_start();
        for (int i = 0; i < 3; i++) begin
            exp_data.push_back(words[i]); exp_row.push_back(2'(i));
            ExE_finish = 1'b1; summation = words[i];
            @(posedge clk); #1;
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== exp_data[0])
                $display("FAIL order_latency%0d: got v=%b d=%h, required v=1 d=%h",
                         i, res_valid, res_data, exp_data[0]);
            else n_pass++;
`ifdef ATC_ROW_TAG_EN
            n_checks++;
            if (res_row !== exp_row[0])
                $display("FAIL order_row%0d: got %0d, required %0d", i, res_row, exp_row[0]);
            else n_pass++;
`endif
            void'(exp_data.pop_front()); void'(exp_row.pop_front());
            ExE_finish = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (level !== 4'd0) $display("FAIL order_level%0d: got %0d, required 0", i, level);
            else n_pass++;
        end
        res_ready = 1'b0;
    endtask

    task automatic test_held_finish();
        do_reset();
        ExE_finish = 1'b1; summation = 32'h41200000;
        repeat (5) @(posedge clk);
        #1 ExE_finish = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (level !== 4'd1) $display("FAIL held_level: got %0d, required 1", level);
        else n_pass++;
        exp_data.push_back(32'h41200000); exp_row.push_back(2'd0);
        drain("held");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            pulse(32'hA000_0000 + 32'(i), 2'd0);
        end
        void'(exp_data.pop_back()); void'(exp_row.pop_back());
        n_checks++;
        if (level !== 4'(DEPTH) || overflow !== 1'b1)
            $display("FAIL ovf_state: got lvl=%0d ov=%b, required lvl=%0d ov=1", level, overflow, DEPTH);
        else n_pass++;
        drain("ovf");
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) pulse(32'hB000_0000 + 32'(i), 2'd0);
        n_checks++;
        if (level !== 4'(DEPTH)) $display("FAIL full_level: got %0d, required %0d", level, DEPTH);
        else n_pass++;
        n_checks++;
        if (res_data !== exp_data[0]) $display("FAIL full_head: got %h, required %h", res_data, exp_data[0]);
        else n_pass++;
        void'(exp_data.pop_front()); void'(exp_row.pop_front());
        exp_data.push_back(32'hC0FFEE00); exp_row.push_back(2'd0);
        ExE_finish = 1'b1; summation = 32'hC0FFEE00; res_ready = 1'b1;
        @(posedge clk); #1;
        ExE_finish = 1'b0; res_ready = 1'b0;
        n_checks++;
        if (level !== 4'(DEPTH) || overflow !== 1'b0)
            $display("FAIL full_pushpop: got lvl=%0d ov=%b, required lvl=%0d ov=0", level, overflow, DEPTH);
        else n_pass++;
        @(posedge clk); #1;
        drain("full");
    endtask

    task automatic test_pass_done();
        do_reset();
        do_pass_start();
        for (int i = 0; i < NUM_ROWS; i++) begin
            exp_data.push_back(32'hD000_0000 + 32'(i)); exp_row.push_back(2'(i));
            ExE_finish = 1'b1; summation = 32'hD000_0000 + 32'(i);
            @(posedge clk); #1;
            n_checks++;
            if (pass_done !== (i == NUM_ROWS - 1))
                $display("FAIL pass_done_row%0d: got %b, required %b", i, pass_done, (i == NUM_ROWS - 1));
            else n_pass++;
            ExE_finish = 1'b0;
            @(posedge clk); #1;
        end
        pulse(32'hD0000099, 2'd0);
        n_checks++;
        if (pass_done !== 1'b1 || level !== 4'd5)
            $display("FAIL pass_done_hold: got pd=%b lvl=%0d, required pd=1 lvl=5", pass_done, level);
        else n_pass++;
        do_pass_start();
        n_checks++;
        if (pass_done !== 1'b0 || level !== 4'd5)
            $display("FAIL pass_restart: got pd=%b lvl=%0d, required pd=0 lvl=5", pass_done, level);
        else n_pass++;
        drain("pass");
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) pulse(32'hE000_0000 + 32'(i), 2'd0);
        n_checks++;
        if (level !== 4'd3) $display("FAIL midrst_pre: got %0d, required 3", level);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (level !== 4'd0 || res_valid !== 1'b0 || overflow !== 1'b0 || res_data !== '0)
            $display("FAIL midrst_async: got lvl=%0d v=%b ov=%b d=%h, required all 0",
                     level, res_valid, overflow, res_data);
        else n_pass++;
        exp_data.delete(); exp_row.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (level !== 4'd0 || res_valid !== 1'b0)
            $display("FAIL midrst_after: got lvl=%0d v=%b, required 0 0", level, res_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_held_finish();
        test_overflow();
        test_full_push_pop();
        test_pass_done();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
